// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch stage's memory, decode and control signals.
// master = fetch unit side, slave = surrounding pipeline / instruction memory.
interface fetch_unit_if #(
   parameter int unsigned DATA_WIDTH                = 32,
   parameter int unsigned INSTRUCTIONMEM_ADDR_WIDTH = 11
);
   // Control from decode / execute
   logic                                 stall;
   logic                                 branchTaken;
   logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] branchTarget;
   logic                                 haltRequest;
   logic                                 resume;

   // Instruction memory read port
   logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] instrAddr;
   logic [DATA_WIDTH-1:0]                instrData;

   // Delivered instruction to decode
   logic [DATA_WIDTH-1:0]                instruction;
   logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] instructionPC;
   logic                                 instructionValid;
   logic                                 halted;

   modport master (
      input  stall,
      input  branchTaken,
      input  branchTarget,
      input  haltRequest,
      input  resume,
      input  instrData,
      output instrAddr,
      output instruction,
      output instructionPC,
      output instructionValid,
      output halted
   );

   modport slave (
      output stall,
      output branchTaken,
      output branchTarget,
      output haltRequest,
      output resume,
      output instrData,
      input  instrAddr,
      input  instruction,
      input  instructionPC,
      input  instructionValid,
      input  halted
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the instruction
// memory read address and hides the memory's one-cycle registered read
// latency, delivering instruction/PC/valid to decode with stall, branch
// redirect/flush and halt/resume support.
// Optional feature macro: FETCH_AUTO_HALT_EN (halt when a delivered word
// carries HALT_OPCODE in its top six bits).
module fetch_unit #(
   parameter int unsigned DATA_WIDTH                = 32,
   parameter int unsigned INSTRUCTIONMEM_ADDR_WIDTH = 11,
   parameter logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter logic [5:0]  HALT_OPCODE               = 6'h3F
) (
   input  logic          clock,
   input  logic          reset,
   fetch_unit_if.master  bus
);

   localparam int unsigned ADDR_W   = INSTRUCTIONMEM_ADDR_WIDTH;
   localparam int unsigned OPCODE_W = 6;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetchState_e;

   fetchState_e       state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pendingPC;
   logic              pendingValid;

   logic              autoHalt;
   logic              issue;

`ifdef FETCH_AUTO_HALT_EN
   logic                deliver;
   logic [OPCODE_W-1:0] deliveredOpcode;

   // A delivered word whose opcode is the halt opcode stops fetching on the same edge
   assign deliver         = !bus.stall && pendingValid;
   assign deliveredOpcode = bus.instrData[DATA_WIDTH-1 -: OPCODE_W];
   assign autoHalt        = deliver && (deliveredOpcode == HALT_OPCODE);
`else
   assign autoHalt = 1'b0;
`endif

   // New fetch is issued only while running, not back-pressured and not halting
   assign issue = (state == RUN) && !bus.stall && !bus.haltRequest && !autoHalt;

   // During a stall re-present the pending address so the memory re-reads that word
   assign bus.instrAddr = (bus.stall && pendingValid) ? pendingPC : pc;

   // PC, pending slot, output stage and RUN/HALTED state
   always_ff @(posedge clock) begin
      if (reset) begin
         pc                   <= RESET_PC;
         pendingPC            <= '0;
         pendingValid         <= 1'b0;
         state                <= RUN;
         bus.halted           <= 1'b0;
         bus.instruction      <= '0;
         bus.instructionPC    <= '0;
         bus.instructionValid <= 1'b0;
      end else if (bus.branchTaken) begin
         // Redirect flushes both the pending and the output stage
         pc                   <= bus.branchTarget;
         pendingValid         <= 1'b0;
         bus.instructionValid <= 1'b0;
      end else begin
         // Output stage: capture the word that arrives this cycle
         if (!bus.stall) begin
            bus.instructionValid <= pendingValid;
            if (pendingValid) begin
               bus.instruction   <= bus.instrData;
               bus.instructionPC <= pendingPC;
            end
         end

         // Issue stage
         if (issue) begin
            pendingPC    <= pc;
            pendingValid <= 1'b1;
            pc           <= pc + ADDR_W'(1);
         end else if (!bus.stall) begin
            pendingValid <= 1'b0;
         end

         // Run/halt state; haltRequest wins over resume while halted
         case (state)
            RUN: begin
               if (bus.haltRequest || autoHalt) begin
                  state      <= HALTED;
                  bus.halted <= 1'b1;
               end
            end
            HALTED: begin
               if (bus.resume && !bus.haltRequest) begin
                  state      <= RUN;
                  bus.halted <= 1'b0;
               end
            end
            default: begin
               state      <= RUN;
               bus.halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with a registered
// one-cycle instruction memory. Expected values are hand-computed.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 11;

   logic clock;
   logic reset;

   int compareCount;
   int mismatchCount;

   logic [DW-1:0] mem [2048];

   fetch_unit_if #(.DATA_WIDTH(DW), .INSTRUCTIONMEM_ADDR_WIDTH(AW)) bus ();

   fetch_unit #(
      .DATA_WIDTH(DW),
      .INSTRUCTIONMEM_ADDR_WIDTH(AW),
      .RESET_PC(11'd0),
      .HALT_OPCODE(6'h3F)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Registered-read instruction memory on the same clock
   always @(posedge clock) bus.instrData <= mem[bus.instrAddr];

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOut(input string tag, input logic valid, input logic [31:0] data, input logic [31:0] pcVal);
      checkValue({tag, ".valid"}, 32'(bus.instructionValid), 32'(valid));
      if (valid) begin
         checkValue({tag, ".instr"}, bus.instruction, data);
         checkValue({tag, ".pc"}, 32'(bus.instructionPC), pcVal);
      end
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[256] = 32'hB000_0100;
`ifdef FETCH_AUTO_HALT_EN
      mem[5] = 32'hFC00_0000;
`endif
      reset            = 1'b1;
      bus.stall        = 1'b0;
      bus.branchTaken  = 1'b0;
      bus.branchTarget = '0;
      bus.haltRequest  = 1'b0;
      bus.resume       = 1'b0;

      // Reset state
      tick(); tick();
      checkValue("rst.valid", 32'(bus.instructionValid), 32'd0);
      checkValue("rst.instr", bus.instruction, 32'd0);
      checkValue("rst.pc", 32'(bus.instructionPC), 32'd0);
      checkValue("rst.halted", 32'(bus.halted), 32'd0);
      checkValue("rst.addr", 32'(bus.instrAddr), 32'd0);

      // Sequential fetch: first word two edges after reset release
      reset = 1'b0;
      tick(); checkOut("seq.e1", 1'b0, 32'd0, 32'd0);
      tick(); checkOut("seq.e2", 1'b1, 32'hA000_0000, 32'd0);

      // Stall 3 cycles while A1 pending: outputs and address frozen
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOut("stall.hold", 1'b1, 32'hA000_0000, 32'd0);
         checkValue("stall.addr", 32'(bus.instrAddr), 32'd1);
      end
      bus.stall = 1'b0;
      tick(); checkOut("stall.rel1", 1'b1, 32'hA000_0001, 32'd1);
      tick(); checkOut("stall.rel2", 1'b1, 32'hA000_0002, 32'd2);

      // Branch to 0x100 while A3 pending: flush, then target two cycles later
      bus.branchTaken  = 1'b1;
      bus.branchTarget = 11'h100;
      tick(); checkOut("br.flush", 1'b0, 32'd0, 32'd0);
      bus.branchTaken = 1'b0;
      tick(); checkOut("br.bubble", 1'b0, 32'd0, 32'd0);
      tick(); checkOut("br.target", 1'b1, 32'hB000_0100, 32'h100);
      tick(); checkOut("br.next", 1'b1, 32'hA000_0101, 32'h101);

      // PC wrap 2047 -> 0
      bus.branchTaken  = 1'b1;
      bus.branchTarget = 11'h7FF;
      tick(); checkOut("wrap.flush", 1'b0, 32'd0, 32'd0);
      bus.branchTaken = 1'b0;
      tick(); checkOut("wrap.bubble", 1'b0, 32'd0, 32'd0);
      tick(); checkOut("wrap.last", 1'b1, 32'hA000_07FF, 32'h7FF);
      tick(); checkOut("wrap.zero", 1'b1, 32'hA000_0000, 32'd0);

      // One-cycle halt request: pending word still delivered, then idle
      bus.haltRequest = 1'b1;
      tick();
      checkOut("halt.drain", 1'b1, 32'hA000_0001, 32'd1);
      checkValue("halt.halted", 32'(bus.halted), 32'd1);
      bus.haltRequest = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOut("halt.idle", 1'b0, 32'd0, 32'd0);
         checkValue("halt.halted2", 32'(bus.halted), 32'd1);
         checkValue("halt.addr", 32'(bus.instrAddr), 32'd2);
      end
      bus.resume = 1'b1;
      tick();
      checkValue("resume.halted", 32'(bus.halted), 32'd0);
      checkOut("resume.e1", 1'b0, 32'd0, 32'd0);
      bus.resume = 1'b0;
      tick(); checkOut("resume.e2", 1'b0, 32'd0, 32'd0);
      tick(); checkOut("resume.e3", 1'b1, 32'hA000_0002, 32'd2);

      // haltRequest and resume together while halted keeps it halted
      bus.haltRequest = 1'b1;
      tick();
      checkOut("both.drain", 1'b1, 32'hA000_0003, 32'd3);
      bus.resume = 1'b1;
      tick();
      checkValue("both.halted", 32'(bus.halted), 32'd1);
      checkOut("both.idle", 1'b0, 32'd0, 32'd0);
      bus.haltRequest = 1'b0;
      tick();
      checkValue("both.resumed", 32'(bus.halted), 32'd0);
      bus.resume = 1'b0;
      tick(); checkOut("both.bubble", 1'b0, 32'd0, 32'd0);
      tick(); checkOut("both.pc4", 1'b1, 32'hA000_0004, 32'd4);

      // Word at PC 5: halt opcode only acts with the optional feature
      tick();
`ifdef FETCH_AUTO_HALT_EN
      checkOut("auto.word", 1'b1, 32'hFC00_0000, 32'd5);
      checkValue("auto.halted", 32'(bus.halted), 32'd1);
      tick();
      checkOut("auto.noPc6", 1'b0, 32'd0, 32'd0);
      checkValue("auto.addr", 32'(bus.instrAddr), 32'd6);
`else
      checkOut("noauto.pc5", 1'b1, 32'hA000_0005, 32'd5);
      checkValue("noauto.halted", 32'(bus.halted), 32'd0);
      tick();
      checkOut("noauto.pc6", 1'b1, 32'hA000_0006, 32'd6);
`endif

      // Reset mid-operation discards everything, then fetch restarts at 0
      reset = 1'b1;
      tick();
      checkValue("rst2.valid", 32'(bus.instructionValid), 32'd0);
      checkValue("rst2.instr", bus.instruction, 32'd0);
      checkValue("rst2.pc", 32'(bus.instructionPC), 32'd0);
      checkValue("rst2.halted", 32'(bus.halted), 32'd0);
      reset = 1'b0;
      tick(); checkOut("rst2.e1", 1'b0, 32'd0, 32'd0);
      tick(); checkOut("rst2.e2", 1'b1, 32'hA000_0000, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory read address.
- Absorbs the memory's 1-cycle registered read latency and delivers each instruction word with its PC and a valid flag to decode.
- Supports stall, branch redirect/flush, and halt/resume.

Parameters:
DATA_WIDTH, 32, instruction word width
INSTRUCTIONMEM_ADDR_WIDTH, 11, word-address width (PC width)
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 6'h3F, opcode in instruction[31:26] that triggers auto-halt (used only with the optional feature)

Ports:
clock  in  1  single clock; memory read clock is tied to the same net
reset  in  1  synchronous, active-high
stall  in  1  decode back-pressure; hold all state and outputs
branchTaken  in  1  redirect request from execute
branchTarget  in  INSTRUCTIONMEM_ADDR_WIDTH  redirect word address
haltRequest  in  1  stop issuing fetches
resume  in  1  leave HALTED
instrAddr  out  INSTRUCTIONMEM_ADDR_WIDTH  to memory readAddr (combinational)
instrData  in  DATA_WIDTH  from memory readData; valid the cycle after the address edge
instruction  out  DATA_WIDTH  registered instruction to decode
instructionPC  out  INSTRUCTIONMEM_ADDR_WIDTH  address of instruction
instructionValid  out  1  instruction/instructionPC meaningful
halted  out  1  state == HALTED

Behaviour:
- Internal registers:
  - pc
  - pendingPC and pendingValid: address issued last edge, data arriving now
  - state in {RUN, HALTED}
- Reset (posedge clock with reset=1):
  - pc=RESET_PC, pendingPC=0, pendingValid=0, state=RUN
  - instruction=0, instructionPC=0, instructionValid=0
  - Reset mid-operation discards pending and output words.
- instrAddr = (stall && pendingValid) ? pendingPC : pc.
  - During a stall the memory re-reads the pending word, so it is not lost.
- Latency: PC issued at edge k; data on instrData during cycle k+1; instruction/instructionValid registered at edge k+1. Total 2 cycles, 1 instruction/cycle sustained.
- Each non-reset edge, evaluate in priority order:
  1. branchTaken:
     - pc=branchTarget, pendingValid=0, instructionValid=0 (flush both stages)
     - state unchanged; overrides stall and haltRequest
  2. Output stage, when !stall:
     - instructionValid=pendingValid
     - if pendingValid: instruction=instrData, instructionPC=pendingPC
     - when stall: outputs hold
  3. Issue:
     - issue = state==RUN && !stall && !haltRequest
     - issue: pendingPC=pc, pendingValid=1, pc=pc+1
     - else if !stall: pendingValid=0
     - else: pending holds
  4. State:
     - RUN→HALTED on haltRequest (no branch)
     - HALTED→RUN on resume
     - haltRequest and resume both high in HALTED: stay HALTED
- PC increment wraps modulo 2^INSTRUCTIONMEM_ADDR_WIDTH (2047→0).
- A word already pending when halt is taken is still delivered. After that, instructionValid=0 while HALTED.
- stall held indefinitely: outputs and pc frozen; no duplicate or dropped instructions on release.

Optional Feature:
FETCH_AUTO_HALT_EN
- Defined:
  - When a word is delivered (output-stage update with pendingValid=1) and instrData[31:26]==HALT_OPCODE, state goes to HALTED on the same edge.
  - The halt word itself is delivered with instructionValid=1.
  - No further issue on that edge: issue is suppressed for that cycle, and the issued-then-discarded pending slot is cleared.
- Undefined: opcode ignored; halting only via haltRequest.

Test Plan:
- Reset, RESET_PC=0, mem[0..3]=A0,A1,A2,A3, no stall -> instructionValid first high 2 cycles after reset release with A0/PC 0, then A1/1, A2/2 on consecutive cycles.
- Stall for 3 cycles while A1 pending -> outputs frozen at A0/0; after release A1/1, A2/2 follow with no skip or duplicate.
- branchTaken with branchTarget=0x100 while A2 pending -> next edge instructionValid=0; 2 cycles later mem[0x100]/0x100 delivered; A2 never appears.
- pc=2047 sequential fetch -> instructionPC 2047 then 0.
- haltRequest 1 cycle -> pending word delivered, then instructionValid=0, halted=1, instrAddr constant; resume -> fetch continues from held pc.
- With FETCH_AUTO_HALT_EN and mem[5]=0xFC000000 -> word at PC 5 delivered valid, halted=1 same edge, PC 6 never delivered.
